pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator for the SoC peripheral bus.
- NCH channels share one prescaler and one period timer. Each channel has its own double-buffered duty, polarity and enable.
- Edge-aligned (up-count) or centre-aligned (up/down) counting is selectable.
- The prescaler produces a clock-enable tick, not a derived clock, so the whole block runs on clk.
- Configuration is written by the bus-side register file.

---
 rtl/pwm_multi_ch.sv | 159 +++++++++++++++
 tb/tb_pwm_multi_ch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler and period timer, per-channel
// double-buffered duty with live polarity and enable, edge or centre aligned.

module pwm_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tmr_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             pol_i,
    input  logic             en_i,
    output logic             pwm_o
);
    logic pwm_q, pwm_d;

    // A disabled channel idles at its polarity level.
    assign pwm_d = en_i ? ((tmr_i < duty_i) ^ pol_i) : pol_i;

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= 1'b0;
        else     pwm_q <= pwm_d;
    end

    assign pwm_o = pwm_q;
endmodule

module pwm_multi_ch #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int PSW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_tmr,
    input  logic                 en_prescalar,
    input  logic [PSW-1:0]       prescale_value,
    input  logic [WIDTH-1:0]     pr_in,
    input  logic [NCH*WIDTH-1:0] duty_in,
    input  logic                 center_in,
    input  logic                 load,
    input  logic [NCH-1:0]       polarity,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH-1:0]       pwm_out,
    output logic [WIDTH-1:0]     tmr,
    output logic                 period_end,
    output logic                 load_pending
);
    typedef struct packed {
        logic [WIDTH-1:0]          pr;
        logic [NCH-1:0][WIDTH-1:0] duty;
        logic                      center;
    } cfg_t;

    cfg_t           act_q, act_d, sh_q, sh_d;
    logic [PSW-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] tmr_q, tmr_d;
    logic           down_q, down_d;
    logic           pend_q, pend_d;
    logic           pe_q;
    logic           tick, boundary, xfer;

    always_comb begin
        tick   = 1'b0;
        pcnt_d = pcnt_q;
        if (!en_tmr) begin
            pcnt_d = '0;
        end else if (!en_prescalar) begin
            tick   = 1'b1;
            pcnt_d = '0;
        end else if (pcnt_q == prescale_value) begin
            tick   = 1'b1;
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_comb begin
        tmr_d    = tmr_q;
        down_d   = down_q;
        boundary = 1'b0;
        if (tick) begin
            if (!act_q.center) begin
                if (tmr_q == act_q.pr) begin
                    tmr_d    = '0;
                    boundary = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end else if (!down_q) begin
                // Peak: hold one extra tick so PR appears twice per period.
                if (tmr_q == act_q.pr) down_d = 1'b1;
                else                   tmr_d  = tmr_q + 1'b1;
            end else begin
                if (tmr_q == '0) begin
                    down_d   = 1'b0;
                    boundary = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
        end

        // A stopped timer has no boundary to wait for, so transfer at once.
        xfer   = pend_q && (boundary || !en_tmr);
        act_d  = act_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        if (xfer) begin
            act_d  = sh_q;
            pend_d = 1'b0;
            tmr_d  = '0;
            down_d = 1'b0;
        end
        if (load) begin
            sh_d.pr     = pr_in;
            sh_d.duty   = duty_in;
            sh_d.center = center_in;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= '0;
            sh_q   <= '0;
            pcnt_q <= '0;
            tmr_q  <= '0;
            down_q <= 1'b0;
            pend_q <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            sh_q   <= sh_d;
            pcnt_q <= pcnt_d;
            tmr_q  <= tmr_d;
            down_q <= down_d;
            pend_q <= pend_d;
            pe_q   <= boundary;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .tmr_i  (tmr_q),
            .duty_i (act_q.duty[i]),
            .pol_i  (polarity[i]),
            .en_i   (ch_en[i]),
            .pwm_o  (pwm_out[i])
        );
    end

    assign tmr          = tmr_q;
    assign period_end   = pe_q;
    assign load_pending = pend_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: table-driven configurations checked cycle by cycle
// against a closed-form waveform model, plus hand sequences for shadow/reset corners.

module tb_pwm_multi_ch;
    localparam int W = 16, N = 4, P = 5;

    logic             clk = 1'b0;
    logic             rst, en_tmr, en_prescalar, center_in, load;
    logic [P-1:0]     prescale_value;
    logic [W-1:0]     pr_in;
    logic [N*W-1:0]   duty_in;
    logic [N-1:0]     polarity, ch_en, pwm_out;
    logic [W-1:0]     tmr;
    logic             period_end, load_pending;

    pwm_multi_ch #(.WIDTH(W), .NCH(N), .PSW(P)) dut (
        .clk(clk), .rst(rst), .en_tmr(en_tmr), .en_prescalar(en_prescalar),
        .prescale_value(prescale_value), .pr_in(pr_in), .duty_in(duty_in),
        .center_in(center_in), .load(load), .polarity(polarity), .ch_en(ch_en),
        .pwm_out(pwm_out), .tmr(tmr), .period_end(period_end), .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               pr;
        logic [N-1:0][W-1:0] duty;
        bit               center;
        bit [N-1:0]       pol;
        bit [N-1:0]       chen;
        bit               psc;
        int               pv;
        int               ncyc;
        logic [N-1:0][7:0] exp_hi;
        int               exp_pe;
    } vec_t;

    typedef struct {
        logic [W-1:0] tmr;
        logic [N-1:0] pwm;
        logic         pe;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   hi_cnt[N];
    int   pe_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timer position after t ticks from a fresh period start.
    function automatic int fold(input vec_t v, input int t);
        int per, ph;
        per = v.center ? 2 * (v.pr + 1) : v.pr + 1;
        ph  = t % per;
        if (v.center && ph > v.pr) return 2 * v.pr + 1 - ph;
        return ph;
    endfunction

    // State observed after the n-th enabled clk edge (n from 0).
    function automatic exp_t model(input vec_t v, input int n);
        exp_t r;
        int d, per, tn, tp;
        d   = v.psc ? v.pv + 1 : 1;
        per = v.center ? 2 * (v.pr + 1) : v.pr + 1;
        tn  = (n + 1) / d;
        tp  = fold(v, n / d);
        r.tmr = W'(fold(v, tn));
        for (int i = 0; i < N; i++)
            r.pwm[i] = v.chen[i] ? ((tp < int'(v.duty[i])) ^ v.pol[i]) : v.pol[i];
        r.pe = ((n + 1) % d == 0) && (tn % per == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_tmr", tmr, e.tmr);
            chk("sb_pwm", pwm_out, e.pwm);
            chk("sb_period_end", period_end, e.pe);
            for (int i = 0; i < N; i++) hi_cnt[i] += int'(pwm_out[i]);
            pe_cnt += int'(period_end);
        end
    end

    // Requires en_tmr=0: capture into shadow, then the stopped timer transfers it.
    task automatic load_cfg(input int pr, input logic [N*W-1:0] duty, input bit center);
        pr_in     = W'(pr);
        duty_in   = duty;
        center_in = center;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        load_cfg(v.pr, v.duty, v.center);
        polarity       = v.pol;
        ch_en          = v.chen;
        en_prescalar   = v.psc;
        prescale_value = P'(v.pv);
        for (int i = 0; i < N; i++) hi_cnt[i] = 0;
        pe_cnt = 0;
        en_tmr = 1'b1;
        for (int n = 0; n < v.ncyc; n++) begin
            @(posedge clk);
            sb.push_back(model(v, n));
        end
        @(negedge clk); #1;
        en_tmr       = 1'b0;
        en_prescalar = 1'b0;
        for (int i = 0; i < N; i++)
            chk($sformatf("vec%0d_high_ch%0d", idx, i), hi_cnt[i], int'(v.exp_hi[i]));
        chk($sformatf("vec%0d_period_ends", idx), pe_cnt, v.exp_pe);
    endtask

    vec_t vt[6];
    int   ha, hb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en_tmr = 1'b0; en_prescalar = 1'b0; prescale_value = '0;
        pr_in = '0; duty_in = '0; center_in = 1'b0; load = 1'b0;
        polarity = '0; ch_en = '0;
        repeat (2) @(negedge clk);
        chk("rst_tmr", tmr, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_period_end", period_end, 0);
        chk("rst_load_pending", load_pending, 0);
        rst = 1'b0;

        //          pr  duty {ch3,ch2,ch1,ch0}                 ctr pol      chen     psc pv ncyc hi {ch3,ch2,ch1,ch0}        pe
        vt[0] = '{9, {16'd0, 16'd0, 16'd0, 16'd3},   0, 4'b0000, 4'b0001, 0, 0, 30, {8'd0, 8'd0, 8'd0, 8'd9},    3};
        vt[1] = '{9, {16'd5, 16'd5, 16'd10, 16'd0},  0, 4'b1100, 4'b0111, 0, 0, 20, {8'd20, 8'd10, 8'd20, 8'd0}, 2};
        vt[2] = '{4, {16'd0, 16'd0, 16'd0, 16'd2},   0, 4'b0000, 4'b0001, 1, 3, 40, {8'd0, 8'd0, 8'd0, 8'd16},   2};
        vt[3] = '{8, {16'd0, 16'd0, 16'd0, 16'd4},   1, 4'b0000, 4'b0001, 0, 0, 36, {8'd0, 8'd0, 8'd0, 8'd16},   2};
        vt[4] = '{0, {16'd0, 16'd0, 16'd0, 16'd1},   1, 4'b0000, 4'b0011, 0, 0, 8,  {8'd0, 8'd0, 8'd0, 8'd8},    4};
        vt[5] = '{3, {16'd0, 16'd1, 16'd4, 16'd2},   0, 4'b0100, 4'b1111, 1, 1, 16, {8'd0, 8'd12, 8'd16, 8'd8},  2};
        foreach (vt[k]) run_vec(vt[k], k);

        // Stopped timer: frozen tmr, live polarity, immediate shadow transfer.
        @(negedge clk);
        load_cfg(9, {48'd0, 16'd6}, 0);
        polarity = '0; ch_en = 4'b0001; en_tmr = 1'b1;
        repeat (5) @(negedge clk);
        chk("frz_run_tmr", tmr, 5);
        en_tmr = 1'b0;
        @(negedge clk);
        chk("frz_tmr", tmr, 5);
        chk("frz_period_end", period_end, 0);
        chk("frz_pwm", pwm_out[0], 1);
        polarity = 4'b0001;
        @(negedge clk);
        chk("frz_live_pol", pwm_out[0], 0);
        polarity = '0; pr_in = 16'd9; duty_in = {48'd0, 16'd2}; load = 1'b1;
        @(negedge clk);
        chk("frz_pend_set", load_pending, 1);
        chk("frz_pend_tmr", tmr, 5);
        load = 1'b0;
        @(negedge clk);
        chk("frz_xfer_pend", load_pending, 0);
        chk("frz_xfer_tmr", tmr, 0);
        @(negedge clk);
        chk("frz_new_duty", pwm_out[0], 1);
        chk("frz_pe_quiet", period_end, 0);

        // Load coinciding with a boundary: active takes the older shadow.
        load_cfg(3, {48'd0, 16'd1}, 0);
        en_tmr = 1'b1; ha = 0; hb = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n >= 4 && n <= 7) ha += int'(pwm_out[0]);
            if (n >= 8) hb += int'(pwm_out[0]);
            if (n == 3) chk("coinc_pend_kept", load_pending, 1);
            if (n == 7) chk("coinc_pend_clr", load_pending, 0);
            load    = (n == 0) || (n == 2);
            duty_in = (n == 0) ? {48'd0, 16'd3} : {48'd0, 16'd0};
        end
        en_tmr = 1'b0; load = 1'b0;
        chk("coinc_high_old_shadow", ha, 3);
        chk("coinc_high_new_shadow", hb, 0);

        // Mid-period duty update takes effect at the wrap.
        @(negedge clk);
        load_cfg(9, {48'd0, 16'd3}, 0);
        en_tmr = 1'b1; ha = 0; hb = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n <= 9) ha += int'(pwm_out[0]);
            else        hb += int'(pwm_out[0]);
            if (n == 4) chk("upd_tmr_at_load", tmr, 5);
            if (n == 5 || n == 8) chk("upd_pend", load_pending, 1);
            if (n == 9) begin
                chk("upd_pend_clr", load_pending, 0);
                chk("upd_period_end", period_end, 1);
            end
            load    = (n == 4);
            duty_in = {48'd0, 16'd7};
        end
        chk("upd_high_old", ha, 3);
        chk("upd_high_new", hb, 7);

        // Reset mid-period with a pending shadow.
        pr_in = 16'd5; duty_in = {48'd0, 16'd2}; load = 1'b1;
        @(negedge clk);
        chk("rst2_pend_before", load_pending, 1);
        load = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst2_tmr", tmr, 0);
        chk("rst2_pwm", pwm_out, 0);
        chk("rst2_pend", load_pending, 0);
        chk("rst2_period_end", period_end, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_pr0_tmr", tmr, 0);
        chk("rst2_pr0_period_end", period_end, 1);
        chk("rst2_pr0_pend", load_pending, 0);
        chk("rst2_pr0_pwm", pwm_out, 0);
        en_tmr = 1'b0;
        @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
